// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
//
// Sits behind the EX/MEM register. It issues byte-masked data-memory reads
// and writes, waits for the single-cycle dmem_resp pulse, aligns and extends
// load data, and loads the MEM/WB register.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   valid_in        EX/MEM holds a live instruction
//   ctrl_in         control word (opcode, funct3, rd, regfilemux_sel, pc, mem_read, mem_write)
//   alu_in          ALU result / effective address
//   wdata_in        rs2 store data
//   br_en_in        compare result
//   u_imm_in        U-type immediate
//   dmem_*          registered data-memory request, rdata/resp from the cache
//   stall           combinational hold for all upstream stage registers
//   wb_*            MEM/WB register outputs (valid, we, rd, data, trap)

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    lw       = 4'd3,
    pc_plus4 = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    regfilemux_sel_t regfilemux_sel;
    logic [31:0]     pc;
    logic            mem_read;
    logic            mem_write;
  } rv32i_control_word;
endpackage

module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  rv32i_control_word ctrl_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       wdata_in,
  input  logic              br_en_in,
  input  logic [31:0]       u_imm_in,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_trap
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_wmask_q, dmem_wmask_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_trap_q, wb_trap_d;

  logic [1:0]  a;
  logic [1:0]  sz;       // funct3[1:0]: 00 byte, 01 half, 10 word
  logic        mem_op;
  logic        misalign;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] res;
  logic        capture;

  assign a      = alu_in[1:0];
  assign sz     = ctrl_in.funct3[1:0];
  assign mem_op = valid_in && (ctrl_in.mem_read || ctrl_in.mem_write);

  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (sz)
        2'b10:   misalign = (a != 2'b00);
        2'b01:   misalign = a[0];
        default: misalign = 1'b0;
      endcase
    end
  end

  // Store lane steering; reads never assert byte enables.
  always_comb begin
    st_mask = 4'b0000;
    st_data = wdata_in;
    if (ctrl_in.mem_write) begin
      case (sz)
        2'b00: begin
          st_mask = 4'b0001 << a;
          st_data = wdata_in << {a, 3'b000};
        end
        2'b01: begin
          st_mask = 4'b0011 << {a[1], 1'b0};
          st_data = wdata_in << {a[1], 4'b0000};
        end
        default: begin
          st_mask = 4'b1111;
          st_data = wdata_in;
        end
      endcase
    end
  end

  // Load extraction and writeback source select.
  assign ld_byte = dmem_rdata[{a, 3'b000} +: 8];
  assign ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    res = alu_in;
    case (ctrl_in.regfilemux_sel)
      alu_out:  res = alu_in;
      br_en:    res = {31'b0, br_en_in};
      u_imm:    res = u_imm_in;
      pc_plus4: res = ctrl_in.pc + 32'd4;
      lw:       res = dmem_rdata;
      lb:       res = {{24{ld_byte[7]}}, ld_byte};
      lbu:      res = {24'b0, ld_byte};
      lh:       res = {{16{ld_half[15]}}, ld_half};
      lhu:      res = {16'b0, ld_half};
      default:  res = alu_in;
    endcase
  end

  // FSM next-state, request latching and MEM/WB capture.
  always_comb begin
    state_d      = state_q;
    dmem_read_d  = dmem_read_q;
    dmem_write_d = dmem_write_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wmask_d = dmem_wmask_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = wb_valid_q;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_trap_d    = wb_trap_q;
    stall        = 1'b0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        // A misaligned access traps straight through without touching memory.
        if (mem_op && !misalign) begin
          stall        = 1'b1;
          state_d      = BUSY;
          dmem_read_d  = ctrl_in.mem_read;
          dmem_write_d = ctrl_in.mem_write;
          dmem_addr_d  = {alu_in[31:2], 2'b00};
          dmem_wmask_d = st_mask;
          dmem_wdata_d = st_data;
        end else begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          capture      = 1'b1;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          state_d      = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      wb_valid_d = valid_in;
      wb_trap_d  = misalign;
      wb_rd_d    = valid_in ? ctrl_in.rd : 5'd0;
      wb_data_d  = res;
      wb_we_d    = valid_in && !misalign && (ctrl_in.rd != 5'd0) &&
                   (ctrl_in.opcode != op_store) && (ctrl_in.opcode != op_br);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wmask_q <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_trap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wmask_q <= dmem_wmask_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_trap_q    <= wb_trap_d;
    end
  end

  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wmask = dmem_wmask_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_trap    = wb_trap_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1 time unit after the rising
// edge, outputs are sampled before the next rising edge.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  rv32i_control_word ctrl;
  logic [31:0]       alu_in, wdata_in, u_imm_in, dmem_rdata;
  logic              br_en_in, dmem_resp;
  logic              dmem_read, dmem_write, stall;
  logic [31:0]       dmem_addr, dmem_wdata, wb_data;
  logic [3:0]        dmem_wmask;
  logic              wb_valid, wb_we, wb_trap;
  logic [4:0]        wb_rd;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl),
    .alu_in(alu_in), .wdata_in(wdata_in), .br_en_in(br_en_in), .u_imm_in(u_imm_in),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_trap(wb_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input rv32i_opcode op, input logic [2:0] f3, input logic [4:0] rd,
                        input regfilemux_sel_t sel, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd);
    valid_in            = 1'b1;
    ctrl.opcode         = op;
    ctrl.funct3         = f3;
    ctrl.rd             = rd;
    ctrl.regfilemux_sel = sel;
    ctrl.mem_read       = mr;
    ctrl.mem_write      = mw;
    alu_in              = alu;
    wdata_in            = wd;
  endtask

  // Runs one access from its IDLE issue cycle through the resp edge.
  // resp is driven in the n-th cycle after issue; request/addr/mask/data
  // are sampled in that cycle.
  task automatic mem_access(input int n, input logic [31:0] rdata,
                            output int rd_cyc, output int wr_cyc, output int st_cyc,
                            output logic [31:0] o_addr, output logic [3:0] o_mask,
                            output logic [31:0] o_wdata);
    rd_cyc = 0; wr_cyc = 0; st_cyc = 0;
    o_addr = '0; o_mask = '0; o_wdata = '0;
    for (int c = 0; c <= n; c++) begin
      if (c == n) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (stall)      st_cyc++;
      if (dmem_read)  rd_cyc++;
      if (dmem_write) wr_cyc++;
      if (c == n) begin
        o_addr = dmem_addr; o_mask = dmem_wmask; o_wdata = dmem_wdata;
      end
      tick();
      dmem_resp = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int          rc, wc, sc;
  logic [31:0] oa, od;
  logic [3:0]  om;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ctrl = '0;
    ctrl.opcode = op_imm; ctrl.regfilemux_sel = alu_out;
    alu_in = '0; wdata_in = '0; u_imm_in = '0; br_en_in = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_read",  {31'b0, dmem_read},  0);
    chk("rst_write", {31'b0, dmem_write}, 0);
    chk("rst_addr",  dmem_addr, 0);
    chk("rst_wmask", {28'b0, dmem_wmask}, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbv",   {31'b0, wb_valid}, 0);
    chk("rst_wbwe",  {31'b0, wb_we}, 0);
    chk("rst_wbd",   wb_data, 0);
    chk("rst_trap",  {31'b0, wb_trap}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    tick();

    // lw 0x1000, resp in the 3rd request cycle
    set_op(op_load, 3'b010, 5'd5, lw, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    mem_access(3, 32'hDEAD_BEEF, rc, wc, sc, oa, om, od);
    chk("lw_rd_cyc", rc, 3);
    chk("lw_st_cyc", sc, 3);
    chk("lw_addr",   oa, 32'h0000_1000);
    chk("lw_mask",   {28'b0, om}, 0);
    valid_in = 1'b0;
    #1;
    chk("lw_rd_clr", {31'b0, dmem_read}, 0);
    chk("lw_data",   wb_data, 32'hDEAD_BEEF);
    chk("lw_we",     {31'b0, wb_we}, 1);
    chk("lw_rdidx",  {27'b0, wb_rd}, 5);
    chk("lw_valid",  {31'b0, wb_valid}, 1);
    tick();

    // sb 0x1003
    set_op(op_store, 3'b000, 5'd3, alu_out, 1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5);
    mem_access(1, 32'h0, rc, wc, sc, oa, om, od);
    chk("sb_wr_cyc", wc, 1);
    chk("sb_mask",   {28'b0, om}, 32'h8);
    chk("sb_wdata",  od, 32'hA500_0000);
    chk("sb_addr",   oa, 32'h0000_1000);
    chk("sb_we",     {31'b0, wb_we}, 0);
    chk("sb_valid",  {31'b0, wb_valid}, 1);

    // sh 0x1002: upper half lanes
    set_op(op_store, 3'b001, 5'd0, alu_out, 1'b0, 1'b1, 32'h0000_1002, 32'h0000_BEEF);
    mem_access(1, 32'h0, rc, wc, sc, oa, om, od);
    chk("sh_mask",   {28'b0, om}, 32'hC);
    chk("sh_wdata",  od, 32'hBEEF_0000);
    // sw 0x1004
    set_op(op_store, 3'b010, 5'd0, alu_out, 1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678);
    mem_access(2, 32'h0, rc, wc, sc, oa, om, od);
    chk("sw_mask",   {28'b0, om}, 32'hF);
    chk("sw_wdata",  od, 32'h1234_5678);
    chk("sw_addr",   oa, 32'h0000_1004);

    // load extraction at 0x2002, rdata 0x80FF1234
    set_op(op_load, 3'b000, 5'd1, lb, 1'b1, 1'b0, 32'h0000_2002, 32'h0);
    mem_access(1, 32'h80FF_1234, rc, wc, sc, oa, om, od);
    chk("lb",  wb_data, 32'hFFFF_FFFF);
    set_op(op_load, 3'b100, 5'd1, lbu, 1'b1, 1'b0, 32'h0000_2002, 32'h0);
    mem_access(1, 32'h80FF_1234, rc, wc, sc, oa, om, od);
    chk("lbu", wb_data, 32'h0000_00FF);
    set_op(op_load, 3'b001, 5'd1, lh, 1'b1, 1'b0, 32'h0000_2002, 32'h0);
    mem_access(1, 32'h80FF_1234, rc, wc, sc, oa, om, od);
    chk("lh",  wb_data, 32'hFFFF_80FF);
    set_op(op_load, 3'b101, 5'd1, lhu, 1'b1, 1'b0, 32'h0000_2002, 32'h0);
    mem_access(1, 32'h80FF_1234, rc, wc, sc, oa, om, od);
    chk("lhu", wb_data, 32'h0000_80FF);
    // lb at byte 1
    set_op(op_load, 3'b000, 5'd1, lb, 1'b1, 1'b0, 32'h0000_2001, 32'h0);
    mem_access(1, 32'h80FF_1234, rc, wc, sc, oa, om, od);
    chk("lb_b1", wb_data, 32'h0000_0012);

    // misaligned lh 0x2001
    set_op(op_load, 3'b001, 5'd4, lh, 1'b1, 1'b0, 32'h0000_2001, 32'h0);
    #1;
    chk("mis_stall", {31'b0, stall}, 0);
    tick();
    chk("mis_read",  {31'b0, dmem_read}, 0);
    chk("mis_trap",  {31'b0, wb_trap}, 1);
    chk("mis_we",    {31'b0, wb_we}, 0);
    chk("mis_valid", {31'b0, wb_valid}, 1);
    // misaligned sw 0x2002
    set_op(op_store, 3'b010, 5'd0, alu_out, 1'b0, 1'b1, 32'h0000_2002, 32'h1);
    tick();
    chk("mis_sw_wr",   {31'b0, dmem_write}, 0);
    chk("mis_sw_trap", {31'b0, wb_trap}, 1);

    // back-to-back lw with N=1
    set_op(op_load, 3'b010, 5'd6, lw, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
    mem_access(1, 32'h1111_2222, rc, wc, sc, oa, om, od);
    chk("b2b0_rd",  rc, 1);
    chk("b2b0_st",  sc, 1);
    chk("b2b0_d",   wb_data, 32'h1111_2222);
    chk("b2b0_trap", {31'b0, wb_trap}, 0);
    set_op(op_load, 3'b010, 5'd7, lw, 1'b1, 1'b0, 32'h0000_3004, 32'h0);
    #1;
    chk("b2b_gap",  {31'b0, dmem_read}, 0);
    mem_access(1, 32'h3333_4444, rc, wc, sc, oa, om, od);
    chk("b2b1_rd",  rc, 1);
    chk("b2b1_st",  sc, 1);
    chk("b2b1_d",   wb_data, 32'h3333_4444);
    chk("b2b1_rdx", {27'b0, wb_rd}, 7);

    // non-memory ops
    set_op(op_reg, 3'b000, 5'd8, alu_out, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0);
    #1;
    chk("add_stall", {31'b0, stall}, 0);
    tick();
    chk("add_d",  wb_data, 32'hCAFE_0001);
    chk("add_we", {31'b0, wb_we}, 1);
    set_op(op_jal, 3'b000, 5'd1, pc_plus4, 1'b0, 1'b0, 32'h0, 32'h0);
    ctrl.pc = 32'hFFFF_FFFC;
    tick();
    chk("pc4_wrap", wb_data, 32'h0);
    set_op(op_lui, 3'b000, 5'd2, u_imm, 1'b0, 1'b0, 32'h0, 32'h0);
    u_imm_in = 32'hABCD_E000;
    tick();
    chk("uimm", wb_data, 32'hABCD_E000);
    set_op(op_reg, 3'b010, 5'd0, br_en, 1'b0, 1'b0, 32'h0, 32'h0);
    br_en_in = 1'b1;
    tick();
    chk("slt_d",    wb_data, 32'h1);
    chk("rd0_we",   {31'b0, wb_we}, 0);
    set_op(op_br, 3'b000, 5'd9, br_en, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("br_we",    {31'b0, wb_we}, 0);
    valid_in = 1'b0;
    tick();
    chk("bubble_v",  {31'b0, wb_valid}, 0);
    chk("bubble_we", {31'b0, wb_we}, 0);

    // reset while BUSY, then a stray resp
    set_op(op_load, 3'b010, 5'd5, lw, 1'b1, 1'b0, 32'h0000_4000, 32'h0);
    tick();
    chk("busy_read", {31'b0, dmem_read}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rstb_read",  {31'b0, dmem_read}, 0);
    chk("rstb_valid", {31'b0, wb_valid}, 0);
    dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_resp = 1'b0;
    chk("stray_read",  {31'b0, dmem_read}, 0);
    chk("stray_valid", {31'b0, wb_valid}, 0);
    set_op(op_reg, 3'b000, 5'd10, alu_out, 1'b0, 1'b0, 32'h0000_0077, 32'h0);
    #1;
    chk("post_stall", {31'b0, stall}, 0);
    tick();
    chk("post_d",  wb_data, 32'h0000_0077);
    chk("post_we", {31'b0, wb_we}, 1);
    valid_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
